// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - single-port framebuffer RAM arbiter, scanout reads vs pixel writer (optional FB_ARB_STARVE_GUARD_EN)
module fb_mem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              SCAN_REQ,
    input  logic [ADDR_W-1:0] SCAN_ADDR,
    output logic              SCAN_GNT,
    output logic              SCAN_RVALID,
    output logic [DATA_W-1:0] SCAN_RDATA,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_GNT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [1:0]        ARB_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              r_mem_we;
    logic              w_mem_we_nxt;
    logic              r_rd_s1;
    logic              r_rd_s2;
    logic [DATA_W-1:0] r_scan_rdata;
    logic              w_force_wr;
    logic              w_scan_gnt;
    logic              w_wr_gnt;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;

    // Count consecutive cycles the writer is held off; saturates, clears on accept or withdrawal
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_starve_cnt <= '0;
        end else if (!WR_REQ || w_wr_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_wr = WR_REQ && (r_starve_cnt == CNT_MAX);
`else
    assign w_force_wr = 1'b0;
`endif

    // Grants are same-cycle; scanout wins unless the writer has waited its limit
    assign w_scan_gnt = !RESET && SCAN_REQ && !w_force_wr;
    assign w_wr_gnt   = !RESET && WR_REQ && (!SCAN_REQ || w_force_wr);
    assign SCAN_GNT   = w_scan_gnt;
    assign WR_GNT     = w_wr_gnt;

    // Next RAM-cycle owner and port contents from this cycle's accept
    always_comb begin
        w_state_nxt     = ST_IDLE;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = 1'b0;
        if (w_scan_gnt) begin
            w_state_nxt    = ST_SCAN;
            w_mem_addr_nxt = SCAN_ADDR;
        end else if (w_wr_gnt) begin
            w_state_nxt     = ST_WRITE;
            w_mem_addr_nxt  = WR_ADDR;
            w_mem_wdata_nxt = WR_DATA;
            w_mem_we_nxt    = 1'b1;
        end
    end

    // Owner state and registered RAM port
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
        end
    end

    // Read return: a SCAN-owned RAM cycle marks the address phase, stage1 tracks the
    // RAM output cycle, stage2 captures the data so it appears two edges after accept
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_rd_s1      <= 1'b0;
            r_rd_s2      <= 1'b0;
            r_scan_rdata <= '0;
        end else begin
            r_rd_s1 <= (r_state == ST_SCAN);
            r_rd_s2 <= r_rd_s1;
            if (r_rd_s1) begin
                r_scan_rdata <= MEM_RDATA;
            end
        end
    end

    assign MEM_ADDR    = r_mem_addr;
    assign MEM_WE      = r_mem_we;
    assign MEM_WDATA   = r_mem_wdata;
    assign ARB_STATE   = r_state;
    assign SCAN_RVALID = r_rd_s2;
    assign SCAN_RDATA  = r_scan_rdata;

endmodule

// File: doc/fb_mem_arbiter.md
# fb_mem_arbiter

Single-port framebuffer memory arbiter sitting between the `vga` scanout engine and the pixel-drawing writer. Shares one synchronous-read RAM port between a scanout read requester (latency-critical, default priority) and a write requester using same-cycle REQ/GNT handshakes. Returns scanout read data with fixed latency and, optionally, bounds writer starvation. One access per cycle, back-to-back.

## Interface
- `ADDR_W`, 19: framebuffer word address width (640x480 = 307200 words).
- `DATA_W`, 8: pixel word width.
- `STARVE_MAX`, 15: writer wait-cycle limit; used only with the starvation guard.

- `CLOCK_50` in 1: the single clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `SCAN_REQ` in 1: scanout read request.
- `SCAN_ADDR` in ADDR_W: scanout read address, stable while SCAN_REQ high and not granted.
- `SCAN_GNT` out 1: combinational; read accepted at the edge where SCAN_REQ && SCAN_GNT.
- `SCAN_RVALID` out 1: registered; SCAN_RDATA valid this cycle.
- `SCAN_RDATA` out DATA_W: registered read data.
- `WR_REQ` in 1: write request.
- `WR_ADDR` in ADDR_W, `WR_DATA` in DATA_W: write address/data, stable until granted.
- `WR_GNT` out 1: combinational; write accepted at the edge where WR_REQ && WR_GNT.
- `MEM_ADDR` out ADDR_W, `MEM_WE` out 1, `MEM_WDATA` out DATA_W: registered RAM port.
- `MEM_RDATA` in DATA_W: RAM read data, valid one cycle after RAM samples MEM_ADDR.
- `ARB_STATE` out 2: registered owner of the current RAM cycle: 0 IDLE, 1 SCAN, 2 WRITE.

## Operation
- Grant logic (combinational, forced 0 while RESET high): `force_wr` = guard active (see Configuration). SCAN_GNT = SCAN_REQ && !force_wr. WR_GNT = WR_REQ && (!SCAN_REQ || force_wr). Never both high.
- On accept edge: scan -> MEM_ADDR<=SCAN_ADDR, MEM_WE<=0, ARB_STATE<=SCAN; write -> MEM_ADDR<=WR_ADDR, MEM_WDATA<=WR_DATA, MEM_WE<=1, ARB_STATE<=WRITE; none -> MEM_WE<=0, ARB_STATE<=IDLE, MEM_ADDR/MEM_WDATA hold.
- Read return: 2-stage valid pipeline. Stage1 set when scan accepted; stage2 <= stage1 and SCAN_RDATA <= MEM_RDATA when stage1 set; SCAN_RVALID = stage2. SCAN_RDATA holds otherwise.
- State transitions: any state -> SCAN/WRITE/IDLE per accept at each edge; no multi-cycle states, no stall.
- Requesters may hold REQ high across consecutive cycles; each edge with REQ&&GNT is a distinct access (address may change every cycle).

## Timing
- Reset values: MEM_ADDR 0, MEM_WE 0, MEM_WDATA 0, SCAN_RVALID 0, SCAN_RDATA 0, ARB_STATE IDLE, pipeline and starve counter 0.
- Accept at edge E: MEM_* valid after E; read data on SCAN_RDATA with SCAN_RVALID after edge E+2 (latency 2). Write committed by RAM at E+1.
- Throughput: 1 access/cycle; full-rate scan gives 1 RVALID/cycle, in address order.
- RESET mid-operation: in-flight reads discarded; no RVALID after RESET deasserts for reads accepted before it.
- Simultaneous REQs: scan wins unless force_wr.
- WR_GNT not seen: requester keeps WR_REQ/WR_ADDR/WR_DATA stable; dropping WR_REQ unaccepted is legal (cancels).

## Configuration
- `FB_ARB_STARVE_GUARD_EN` defined: counter (width clog2(STARVE_MAX+1)) increments each cycle WR_REQ && !WR_GNT, saturates at STARVE_MAX, clears on write accept or WR_REQ low. force_wr = WR_REQ && count == STARVE_MAX: writer waits at most STARVE_MAX cycles, then wins one cycle over scan.
- Undefined: no counter, force_wr = 0, strict scan priority (writer may starve indefinitely).

## Test plan
- Scan-only, SCAN_REQ held 4 cycles with SCAN_ADDR 0,1,2,3, RAM preloaded addr+0x10 -> SCAN_GNT high 4 cycles; RVALID 4 consecutive cycles starting 2 edges after first accept, data 0x10..0x13.
- Write-only, WR_ADDR=0x12345, WR_DATA=0xA5 -> WR_GNT same cycle; next cycle MEM_WE=1, MEM_ADDR=0x12345, MEM_WDATA=0xA5, ARB_STATE=WRITE; then MEM_WE=0, ARB_STATE=IDLE.
- Both requesting continuously, guard undefined -> WR_GNT stays 0 for 100 cycles; drop SCAN_REQ -> WR_GNT high same cycle.
- Both continuously, guard defined, STARVE_MAX=15 -> writer granted on 16th cycle; SCAN_GNT low that cycle only; then counter 0 and pattern repeats every 16 cycles.
- Scan accept then RESET pulse one cycle later -> SCAN_RVALID stays 0; all outputs at reset values; first post-reset accept returns data after 2 edges.
- Alternating scan/write at addr 5 (write 0x3C then read 5) -> read returns 0x3C with correct latency.
